// File: rtl/invol_arbiter_pkg.sv
// Shared command package: arbiter states, unit indices and sizing.
// Used by the command engine and by every unit that requests sends.
package invol_arbiter_pkg;

  localparam int NUM_UNITS = 5;

  localparam int UNIT_0 = 0;
  localparam int UNIT_1 = 1;
  localparam int UNIT_2 = 2;
  localparam int UNIT_3 = 3;
  localparam int UNIT_4 = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/invol_arbiter_rr_pick.sv
// Round-robin selector: first set request at or after ptr,
// wrapping from NUNITS-1 back to 0.
module rr_pick #(
  parameter int NUNITS    = 5,
  parameter int UNIT_BITS = $clog2(NUNITS)
) (
  input  logic [NUNITS-1:0]    req,
  input  logic [UNIT_BITS-1:0] ptr,
  output logic                 valid,
  output logic [UNIT_BITS-1:0] idx
);

  int j;

  // Scan from the farthest offset down so the nearest one wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = NUNITS - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUNITS) j = j - NUNITS;
      if (req[j]) begin
        valid = 1'b1;
        idx   = j[UNIT_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/invol_arbiter.sv
// Involuntary-send arbiter: grants one unit at a time to the
// command engine, round-robin, with a done/timeout release.
module invol_arbiter
  import invol_arbiter_pkg::*;
#(
  parameter int NUNITS    = NUM_UNITS,
  parameter int TIMEOUT   = 4096,
  parameter int UNIT_BITS = $clog2(NUNITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUNITS-1:0]    invol_req,
  input  logic                 engine_idle,
  input  logic [NUNITS-1:0]    unit_cmd_done,
  output logic [NUNITS-1:0]    invol_grant,
  output logic [UNIT_BITS-1:0] active_unit,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [7:0]           timeout_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [UNIT_BITS-1:0] U_LAST =
    UNIT_BITS'(NUNITS - 1);

  arb_state_e           state_q, state_d;
  logic [UNIT_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUNITS-1:0]    grant_q, grant_d;
  logic [UNIT_BITS-1:0] active_q, active_d;
  logic                 busy_q, busy_d;
  logic                 terr_q, terr_d;
  logic [7:0]           tcnt_q, tcnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 arm_q, arm_d;

  logic                 pick_vld;
  logic [UNIT_BITS-1:0] pick_idx;
  logic [UNIT_BITS-1:0] nxt_ptr;

  rr_pick #(
    .NUNITS   (NUNITS),
    .UNIT_BITS(UNIT_BITS)
  ) u_pick (
    .req  (invol_req),
    .ptr  (rr_ptr_q),
    .valid(pick_vld),
    .idx  (pick_idx)
  );

  assign nxt_ptr = (active_q == U_LAST) ? '0
                 : active_q + UNIT_BITS'(1);

  // arm_q holds off the first grant until one edge after reset.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = '0;
    active_d = active_q;
    busy_d   = busy_q;
    terr_d   = 1'b0;
    tcnt_d   = tcnt_q;
    timer_d  = timer_q;
    arm_d    = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (arm_q && engine_idle && pick_vld) begin
          state_d  = ST_GRANT;
          grant_d  = NUNITS'(1) << pick_idx;
          active_d = pick_idx;
          busy_d   = 1'b1;
          timer_d  = '0;
        end
      end
      ST_GRANT: begin
        state_d = ST_WAIT_DONE;
        timer_d = timer_q + TW'(1);
      end
      ST_WAIT_DONE: begin
        if (unit_cmd_done[active_q]) begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          rr_ptr_d = nxt_ptr;
        end else if (timer_q >= T_LAST) begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          rr_ptr_d = nxt_ptr;
          terr_d   = 1'b1;
          tcnt_d   = sat_inc8(tcnt_q);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      active_q <= '0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      tcnt_q   <= '0;
      timer_q  <= '0;
      arm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
      tcnt_q   <= tcnt_d;
      timer_q  <= timer_d;
      arm_q    <= arm_d;
    end
  end

  assign invol_grant = grant_q;
  assign active_unit = active_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_invol_arbiter.sv
// Scoreboard bench for invol_arbiter: stimulus queues expected
// grant/timeout events, a negedge monitor pops and compares.
module tb_invol_arbiter;

  logic       clk;
  logic       rst_n;
  logic [4:0] invol_req;
  logic       engine_idle;
  logic [4:0] unit_cmd_done;
  logic [4:0] invol_grant;
  logic [2:0] active_unit;
  logic       busy;
  logic       timeout_err;
  logic [7:0] timeout_cnt;

  invol_arbiter #(
    .NUNITS (5),
    .TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .invol_req    (invol_req),
    .engine_idle  (engine_idle),
    .unit_cmd_done(unit_cmd_done),
    .invol_grant  (invol_grant),
    .active_unit  (active_unit),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .timeout_cnt  (timeout_cnt)
  );

  typedef struct {
    bit   terr;
    int   unit;
    int   val;
    int   cyc;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   g;
  bit   ok;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic push_g(input int unit, input int c);
    exp_t e;
    e.terr = 1'b0;
    e.unit = unit;
    e.val  = 1 << unit;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic push_t(input int cnt, input int c);
    exp_t e;
    e.terr = 1'b1;
    e.unit = 0;
    e.val  = cnt;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic reset_dut();
    rst_n         = 1'b0;
    invol_req     = '0;
    engine_idle   = 1'b0;
    unit_cmd_done = '0;
    tick(1);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && invol_grant != '0) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL grant_unexpected: got %b at %0d want none",
                 invol_grant, cyc);
      end else begin
        m_e = q.pop_front();
        ok = !m_e.terr && int'(invol_grant) == m_e.val
             && busy && int'(active_unit) == m_e.unit
             && cyc == m_e.cyc;
        if (!ok) begin
          n_bad++;
          $display("FAIL grant: got %b unit %0d busy %0b cyc %0d want %s %0h unit %0d cyc %0d",
                   invol_grant, active_unit, busy, cyc,
                   m_e.terr ? "terr" : "grant", m_e.val,
                   m_e.unit, m_e.cyc);
        end
      end
    end
    if (rst_n && timeout_err) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL terr_unexpected: got pulse at %0d want none",
                 cyc);
      end else begin
        m_e = q.pop_front();
        ok = m_e.terr && int'(timeout_cnt) == m_e.val
             && !busy && cyc == m_e.cyc;
        if (!ok) begin
          n_bad++;
          $display("FAIL terr: got cnt %0d busy %0b cyc %0d want %s %0d cyc %0d",
                   timeout_cnt, busy, cyc,
                   m_e.terr ? "terr" : "grant", m_e.val, m_e.cyc);
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    invol_req     = '0;
    engine_idle   = 1'b0;
    unit_cmd_done = '0;
    tick(2);
    chk("rst_grant", int'(invol_grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_active", int'(active_unit), 0);
    chk("rst_terr", int'(timeout_err), 0);
    chk("rst_tcnt", int'(timeout_cnt), 0);

    // two requesters, pointer at 0; first grant two edges after reset
    rst_n       = 1'b1;
    invol_req   = 5'b00110;
    engine_idle = 1'b1;
    g = cyc + 2;
    push_g(1, g);
    tick(2);
    invol_req = 5'b00100;
    tick(1);
    unit_cmd_done = 5'b00010;
    push_g(2, g + 3);
    tick(1);
    unit_cmd_done = '0;
    chk("busy_after_done", int'(busy), 0);
    tick(1);
    invol_req = '0;
    tick(1);
    unit_cmd_done = 5'b00100;
    tick(1);
    unit_cmd_done = '0;
    tick(2);

    // all five request, done three cycles after each grant
    reset_dut();
    invol_req   = 5'b11111;
    engine_idle = 1'b1;
    g = cyc + 2;
    for (int k = 0; k < 6; k++) push_g(k % 5, g + 5 * k);
    tick(2);
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        tick(1);
        unit_cmd_done = 5'b00010;
        tick(1);
        unit_cmd_done = '0;
        tick(1);
      end else begin
        tick(3);
      end
      unit_cmd_done = 5'(1 << (k % 5));
      if (k == 5) invol_req = '0;
      tick(1);
      unit_cmd_done = '0;
      tick(1);
    end
    tick(2);

    // unit 3 never completes; unit 4 is next in line
    reset_dut();
    invol_req   = 5'b11000;
    engine_idle = 1'b1;
    g = cyc + 2;
    push_g(3, g);
    push_t(1, g + 16);
    push_g(4, g + 17);
    tick(2);
    chk("busy_in_grant", int'(busy), 1);
    tick(16);
    chk("busy_after_to", int'(busy), 0);
    chk("tcnt_after_to", int'(timeout_cnt), 1);
    tick(1);
    invol_req = '0;

    // done lands on the terminal timer cycle: done wins
    tick(15);
    unit_cmd_done = 5'b10000;
    tick(1);
    unit_cmd_done = '0;
    chk("busy_done_term", int'(busy), 0);
    chk("tcnt_done_term", int'(timeout_cnt), 1);
    tick(3);

    // engine busy holds the request back, then grants next cycle
    engine_idle = 1'b0;
    invol_req   = 5'b10000;
    tick(10);
    push_g(4, cyc + 1);
    engine_idle = 1'b1;
    tick(1);
    invol_req = '0;
    tick(2);
    chk("busy_wait_done", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_grant", int'(invol_grant), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_active", int'(active_unit), 0);
    chk("async_terr", int'(timeout_err), 0);
    chk("async_tcnt", int'(timeout_cnt), 0);
    tick(1);
    rst_n = 1'b1;
    tick(20);

    // withdrawn request must not be granted
    engine_idle = 1'b0;
    invol_req   = 5'b00001;
    tick(3);
    invol_req   = 5'b00100;
    engine_idle = 1'b1;
    push_g(2, cyc + 1);
    tick(1);
    invol_req = '0;
    tick(1);
    unit_cmd_done = 5'b00100;
    tick(1);
    unit_cmd_done = '0;
    tick(2);

    // repeated timeouts: counter saturates at 255
    reset_dut();
    invol_req   = 5'b00001;
    engine_idle = 1'b1;
    g = cyc + 2;
    for (int k = 1; k <= 257; k++) begin
      push_g(0, g + 17 * (k - 1));
      push_t(k > 255 ? 255 : k, g + 17 * (k - 1) + 16);
    end
    tick(2 + 17 * 256 + 16);
    invol_req = '0;
    tick(3);
    chk("tcnt_saturated", int'(timeout_cnt), 255);
    chk("busy_end", int'(busy), 0);

    tick(4);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/invol_arbiter.md
INVOL_ARBITER -- requirements
Module: invol_arbiter

Interface
REQ-001 The block SHALL have parameter NUNITS, default 5, giving the number of units that can request involuntary sends.
REQ-002 The block SHALL have parameter TIMEOUT, default 4096, giving the maximum clk cycles from grant to done before the grant is aborted.
REQ-003 The block SHALL have parameter UNIT_BITS, default $clog2(NUNITS), giving the width of the unit index.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset.
REQ-005 Port clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-007 Port invol_req: input, NUNITS bits, level request per unit; held until the unit is served.
REQ-008 Port engine_idle: input, 1 bit; the command engine is idle and no host message is pending.
REQ-009 Port unit_cmd_done: input, NUNITS bits; one-cycle pulse per unit when its response is complete.
REQ-010 Port invol_grant: output, NUNITS bits, registered; at most one bit high, for one cycle.
REQ-011 Port active_unit: output, UNIT_BITS bits, registered; index of the unit currently granted.
REQ-012 Port busy: output, 1 bit, registered; high from the grant cycle until release.
REQ-013 Port timeout_err: output, 1 bit, registered; one-cycle pulse when a grant is aborted.
REQ-014 Port timeout_cnt: output, 8 bits, registered; saturating count of aborted grants.

Function
REQ-015 The block SHALL implement three states: IDLE, GRANT and WAIT_DONE.
REQ-016 In IDLE, when engine_idle=1 and invol_req!=0, the block SHALL select the first requesting unit at or after rr_ptr in ascending index order, wrapping from NUNITS-1 to 0, and enter GRANT.
REQ-017 In the GRANT state, the block SHALL set invol_grant[sel] for exactly one cycle, set busy=1 and active_unit=sel, clear the timer, and enter WAIT_DONE.
REQ-018 Latency: a request sampled in cycle N SHALL produce its grant pulse in cycle N+1.
REQ-019 In WAIT_DONE, unit_cmd_done[active_unit]=1 SHALL return the state to IDLE with busy=0 and rr_ptr=(active_unit+1) mod NUNITS.
REQ-020 Done pulses from units other than active_unit SHALL be ignored.
REQ-021 The timer SHALL count cycles in WAIT_DONE; reaching TIMEOUT without done SHALL pulse timeout_err, increment timeout_cnt (saturating at 255), advance rr_ptr as in REQ-019, and return to IDLE.
REQ-022 When done and timeout occur in the same cycle, done SHALL win and timeout_err SHALL remain 0.
REQ-023 When engine_idle=0 in IDLE, no grant SHALL be issued; pending requests SHALL be retained.
REQ-024 A request that is withdrawn before selection SHALL NOT be granted; selection SHALL use only the current-cycle invol_req.
REQ-025 The earliest next grant after a release SHALL be one cycle after the return to IDLE; no back-to-back grant pulses SHALL occur.
REQ-026 rr_ptr SHALL always remain in 0..NUNITS-1.

Reset
REQ-027 On rst_n=0, the block SHALL asynchronously force state=IDLE, rr_ptr=0, invol_grant=0, active_unit=0, busy=0, timeout_err=0, timeout_cnt=0 and timer=0.
REQ-028 A reset asserted in GRANT or WAIT_DONE SHALL abandon the grant without a timeout_err pulse.
REQ-029 After rst_n deasserts, the first grant SHALL be issued no earlier than the second rising edge.

Structure
REQ-030 State encodings, UNIT_* indices and NUNITS SHALL be placed in a shared command package used by command and unit modules.
REQ-031 The round-robin first-set-at-or-after selector SHALL be a combinational sub-module named rr_pick, parameterised by NUNITS.
REQ-032 The timeout counter SHALL be inline.

Verification
REQ-033 Scenario: invol_req=5'b00110, engine_idle=1, rr_ptr=0 -> grant 5'b00010 next cycle; after done[1], grant 5'b00100.
REQ-034 Scenario: all five units request continuously, each completing done 3 cycles after its grant -> grant order 0,1,2,3,4,0 with no repeats.
REQ-035 Scenario: unit 3 granted and never signals done, TIMEOUT=16 -> timeout_err pulses 16 cycles after the grant, timeout_cnt=1, busy=0, next grant goes to unit 4 if it requests.
REQ-036 Scenario: done[active_unit] coincides with the terminal timer cycle -> no timeout_err, timeout_cnt unchanged.
REQ-037 Scenario: engine_idle=0 with invol_req=5'b10000 for 10 cycles -> no grant; engine_idle rises -> grant 5'b10000 one cycle later.
REQ-038 Scenario: rst_n pulled low in WAIT_DONE -> all outputs 0 immediately, without waiting for the clock edge.
